adder_response_checker: RTL
===========================

# adder_response_checker

Self-checking response monitor for the ripple-carry adder benches. It is the receiving end of the stimulus stream that drives an adder DUT. It samples each applied operand vector, predicts the sum and carry, and compares the prediction against the DUT outputs a fixed number of clocks later. It keeps error and check counts and reports a final pass/fail verdict, so the benches no longer need manual waveform inspection.

## Interface

Parameters:
- WIDTH, default 8: operand width in bits; legal range 1..16.
- LATENCY, default 1: clocks from vector sample to DUT output sample; legal range 1..8.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: begin a checking run.
- stop, in, 1: end a checking run.
- in_valid, in, 1: a, b and cin hold a vector applied to the DUT this cycle.
- a, in, WIDTH: operand A.
- b, in, WIDTH: operand B.
- cin, in, 1: carry in.
- dut_sum, in, WIDTH: DUT sum output.
- dut_cout, in, 1: DUT carry output.
- chk_valid, out, 1: a comparison happened this cycle.
- mismatch, out, 1: that comparison failed; meaningful only with chk_valid.
- check_count, out, 16: comparisons performed; saturates at 16'hFFFF.
- err_count, out, 16: mismatches; saturates at 16'hFFFF.
- busy, out, 1: state is RUN or DRAIN.
- done, out, 1: state is DONE.
- pass, out, 1: done && err_count == 0.

## Operation

- Expected value is a + b + cin, computed at WIDTH+1 bits.
  - Bit WIDTH is the expected cout.
  - Bits WIDTH-1..0 are the expected sum.
  - There is no truncation before the add.
- A LATENCY-deep pipeline carries {valid, expected sum, expected cout} together with the sampled a, b and cin.

State machine:
- IDLE, the reset state. Nothing is sampled and the counters hold. start moves to RUN and clears both counters.
- RUN. On every edge with in_valid high, a vector enters the pipeline. stop moves to DRAIN. start is ignored.
- DRAIN. in_valid is ignored and no new vectors enter. Vectors already in the pipeline are still compared. When no valid entry is left, the state moves to DONE.
- DONE. Counters hold, and done and pass are valid. start moves to RUN and clears the counters. stop is ignored.

Simultaneous start and stop:
- In IDLE or DONE, start wins.
- In RUN, stop wins.

Comparison:
- A pipeline entry that reaches depth LATENCY is compared against dut_sum and dut_cout sampled on the same edge.
- On a mismatch, err_count increments. check_count increments on every comparison.
- Saturation: a counter at 16'hFFFF holds that value and does not wrap.
- A vector sampled on the edge that moves RUN to DRAIN (stop high) is not captured.

## Timing

- A vector sampled at edge k is compared at edge k+LATENCY.
- chk_valid and mismatch are registered outputs. They are high for exactly the one cycle following edge k+LATENCY.
- Counters update at the same edge as the comparison.
- Back-to-back valid vectors are supported at full rate: one comparison per clock.
- DRAIN lasts at most LATENCY cycles. DONE is entered on the edge after the last comparison.
- Reset values: every output is 0, all pipeline valid bits are 0, and the state is IDLE.
- Reset asserted mid-run discards pipeline contents, clears the counters and returns to IDLE. No partial comparison is reported.

## Configuration

- Macro ADDER_CHK_FIRST_ERR_EN:
  - Defined: adds outputs first_err_a (WIDTH), first_err_b (WIDTH), first_err_cin (1) and first_err_valid (1). These latch the operands of the first mismatch after start. They are cleared by start and by rst, and they hold until then.
  - Undefined: those ports and registers are absent. All other behaviour is identical.

## Test plan

1. WIDTH=8, LATENCY=1, ideal DUT model. Sweep the 8 combinations of a, b, cin over {0, 1} in the low bit, then stop -> check_count=8, err_count=0, done=1 and pass=1 within 2 clocks of stop.
2. a=8'hFF, b=8'h01, cin=1, DUT returns sum=8'h01 and cout=1 -> chk_valid=1 and mismatch=0 one clock after the sample edge. Then a DUT forcing cout=0 -> mismatch=1, err_count=1, and pass=0 after stop.
3. LATENCY=3, 10 consecutive valid vectors with stop asserted on the edge after the last one -> exactly 10 chk_valid pulses, busy stays high through DRAIN, and done rises 3 clocks after stop.
4. start and stop high together in RUN -> enters DRAIN. start and stop high together in DONE -> RUN with counters at 0.
5. Assert rst while 2 vectors are in flight (LATENCY=3) -> no chk_valid pulse, all outputs 0, state IDLE. A following start run counts from 0.
6. With ADDER_CHK_FIRST_ERR_EN defined, inject mismatches on vectors (a=8'h12, b=8'h34, cin=0) then (a=8'h56, b=8'h78, cin=1) -> first_err_a=8'h12, first_err_b=8'h34, first_err_cin=0, err_count=2.

Source files
------------

// File: rtl/adder_response_checker.sv
// adder_response_checker: predicts a + b + cin for each vector applied to an adder DUT
//   and compares the prediction with the DUT outputs LATENCY clocks later.
//   It keeps saturating check/error counters and gives a done/pass verdict.
// Latency: a vector sampled at edge k is compared at edge k+LATENCY; chk_valid/mismatch
//   are registered, so they are high during the cycle after that edge. Full rate, no stalls.
// Ports: clk/rst (async active-high); start/stop run control; in_valid/a/b/cin vector in;
//   dut_sum/dut_cout DUT response; chk_valid/mismatch per-compare result;
//   check_count/err_count saturating counters; busy/done/pass run status.
// Option macro ADDER_CHK_FIRST_ERR_EN adds first_err_a/b/cin/valid, which latch the
//   operands of the first mismatch after start.
module adder_response_checker #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_cout,
    output logic             chk_valid,
    output logic             mismatch,
    output logic [15:0]      check_count,
    output logic [15:0]      err_count,
    output logic             busy,
    output logic             done,
    output logic             pass
`ifdef ADDER_CHK_FIRST_ERR_EN
    ,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b,
    output logic             first_err_cin,
    output logic             first_err_valid
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // The operands only have a consumer when first-error capture is built in.
    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
`ifdef ADDER_CHK_FIRST_ERR_EN
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
`endif
    } entry_t;

    state_t             state_q, state_d;
    logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    entry_t             pipe_q [LATENCY];
    entry_t             pipe_d [LATENCY];
    logic               chk_valid_q, chk_valid_d;
    logic               mismatch_q, mismatch_d;
    logic [15:0]        check_count_q, check_count_d;
    logic [15:0]        err_count_q, err_count_d;

    logic               capture;
    logic               clear;
    logic               cmp_en;
    logic               cmp_fail;
    logic [WIDTH:0]     exp_full;
    entry_t             head;

`ifdef ADDER_CHK_FIRST_ERR_EN
    logic [WIDTH-1:0]   first_err_a_q, first_err_a_d;
    logic [WIDTH-1:0]   first_err_b_q, first_err_b_d;
    logic               first_err_cin_q, first_err_cin_d;
    logic               first_err_valid_q, first_err_valid_d;
`endif

    // Full WIDTH+1 bit add: the top bit is the expected carry out.
    always_comb begin
        exp_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    end

    // Run control. stop beats start in RUN; start beats stop in IDLE/DONE.
    // A vector offered on the stop edge is deliberately not captured.
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    clear   = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_DRAIN;
                end else begin
                    capture = in_valid;
                end
            end
            ST_DRAIN: begin
                // Empty pipeline means the last compare happened on the previous edge.
                if (pipe_vld_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    clear   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Compare the oldest entry against the DUT response present on this edge.
    always_comb begin
        head     = pipe_q[LATENCY-1];
        cmp_en   = pipe_vld_q[LATENCY-1];
        cmp_fail = cmp_en && ({dut_cout, dut_sum} != {head.cout, head.sum});
    end

    always_comb begin
        pipe_vld_d     = '0;
        pipe_vld_d[0]  = capture;
        pipe_d[0]      = '0;
        pipe_d[0].sum  = exp_full[WIDTH-1:0];
        pipe_d[0].cout = exp_full[WIDTH];
`ifdef ADDER_CHK_FIRST_ERR_EN
        pipe_d[0].a    = a;
        pipe_d[0].b    = b;
        pipe_d[0].cin  = cin;
`endif
        for (int i = 1; i < LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_d[i]     = pipe_q[i-1];
        end
    end

    always_comb begin
        check_count_d = check_count_q;
        err_count_d   = err_count_q;
        chk_valid_d   = cmp_en;
        mismatch_d    = cmp_fail;
        if (clear) begin
            check_count_d = '0;
            err_count_d   = '0;
        end else if (cmp_en) begin
            if (check_count_q != 16'hFFFF) begin
                check_count_d = check_count_q + 16'd1;
            end
            if (cmp_fail && (err_count_q != 16'hFFFF)) begin
                err_count_d = err_count_q + 16'd1;
            end
        end
    end

`ifdef ADDER_CHK_FIRST_ERR_EN
    always_comb begin
        first_err_a_d     = first_err_a_q;
        first_err_b_d     = first_err_b_q;
        first_err_cin_d   = first_err_cin_q;
        first_err_valid_d = first_err_valid_q;
        if (clear) begin
            first_err_a_d     = '0;
            first_err_b_d     = '0;
            first_err_cin_d   = 1'b0;
            first_err_valid_d = 1'b0;
        end else if (cmp_fail && !first_err_valid_q) begin
            first_err_a_d     = head.a;
            first_err_b_d     = head.b;
            first_err_cin_d   = head.cin;
            first_err_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_err_a_q     <= '0;
            first_err_b_q     <= '0;
            first_err_cin_q   <= 1'b0;
            first_err_valid_q <= 1'b0;
        end else begin
            first_err_a_q     <= first_err_a_d;
            first_err_b_q     <= first_err_b_d;
            first_err_cin_q   <= first_err_cin_d;
            first_err_valid_q <= first_err_valid_d;
        end
    end

    assign first_err_a     = first_err_a_q;
    assign first_err_b     = first_err_b_q;
    assign first_err_cin   = first_err_cin_q;
    assign first_err_valid = first_err_valid_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pipe_vld_q    <= '0;
            chk_valid_q   <= 1'b0;
            mismatch_q    <= 1'b0;
            check_count_q <= '0;
            err_count_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            pipe_vld_q    <= pipe_vld_d;
            chk_valid_q   <= chk_valid_d;
            mismatch_q    <= mismatch_d;
            check_count_q <= check_count_d;
            err_count_q   <= err_count_d;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign chk_valid   = chk_valid_q;
    assign mismatch    = mismatch_q;
    assign check_count = check_count_q;
    assign err_count   = err_count_q;
    assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);
    assign pass        = (state_q == ST_DONE) && (err_count_q == 16'd0);

endmodule
